fib_seq_checker: RTL and testbench

//   Downstream consumer of the 4-bit fibonacci generator output stream.

---
 rtl/fib_seq_checker.sv | 159 +++++++++++++++
 tb/tb_fib_seq_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_checker.sv
// Fibonacci stream checker: self-seeds from the first two accepted samples,
// predicts each next term modulo 2^W, and counts terms and deviations.
module fib_seq_checker #(
    parameter int unsigned W          = 4,
    parameter int unsigned CW         = 8,
    parameter bit          CHECK_SEED = 1'b1,
    parameter int unsigned SEED0      = 1,
    parameter int unsigned SEED1      = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          restart,
    input  logic          clr_err,
    output logic          locked,
    output logic [W-1:0]  expected,
    output logic          err_pulse,
    output logic          mismatch_sticky,
    output logic [CW-1:0] term_cnt,
    output logic [CW-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [W-1:0] SEED0_W = W'(SEED0);
    localparam logic [W-1:0] SEED1_W = W'(SEED1);

    state_t        state_q, state_d;
    logic [W-1:0]  prev0_q, prev0_d;
    logic [W-1:0]  prev1_q, prev1_d;
    logic [W-1:0]  expected_q, expected_d;
    logic          resync_q, resync_d;
    logic          locked_q, locked_d;
    logic          err_pulse_q, err_pulse_d;
    logic          sticky_q, sticky_d;
    logic [CW-1:0] term_cnt_q, term_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic err;

    always_comb begin
        state_d  = state_q;
        prev0_d  = prev0_q;
        prev1_d  = prev1_q;
        resync_d = resync_q;
        err      = 1'b0;
        accept   = in_valid && !restart;

        if (restart) begin
            state_d  = IDLE;
            prev0_d  = '0;
            prev1_d  = '0;
            resync_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (CHECK_SEED && (in_data != SEED0_W)) begin
                        err = 1'b1;
                    end else begin
                        prev1_d  = in_data;
                        resync_d = 1'b0;
                        state_d  = SEED;
                    end
                end
                SEED: begin
                    // A pair re-seeded after a TRACK mismatch is taken as-is.
                    if (CHECK_SEED && !resync_q && (in_data != SEED1_W)) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        prev0_d = prev1_q;
                        prev1_d = in_data;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (in_data == expected_q) begin
                        prev0_d = prev1_q;
                        prev1_d = in_data;
                    end else begin
                        err      = 1'b1;
                        prev1_d  = in_data;
                        resync_d = 1'b1;
                        state_d  = SEED;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        expected_d  = prev0_d + prev1_d;
        locked_d    = (state_d == TRACK);
        err_pulse_d = err;

        term_cnt_d = term_cnt_q;
        if (restart) begin
            term_cnt_d = '0;
        end else if (accept && (term_cnt_q != '1)) begin
            term_cnt_d = term_cnt_q + 1'b1;
        end

        // An error in the same cycle as clr_err restarts the count at one.
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;
        if (err) begin
            sticky_d = 1'b1;
            if (clr_err) begin
                err_cnt_d = CW'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (clr_err) begin
            err_cnt_d = '0;
            sticky_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            prev0_q     <= '0;
            prev1_q     <= '0;
            expected_q  <= '0;
            resync_q    <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
            term_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev0_q     <= prev0_d;
            prev1_q     <= prev1_d;
            expected_q  <= expected_d;
            resync_q    <= resync_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sticky_q    <= sticky_d;
            term_cnt_q  <= term_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked          = locked_q;
    assign expected        = expected_q;
    assign err_pulse       = err_pulse_q;
    assign mismatch_sticky = sticky_q;
    assign term_cnt        = term_cnt_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Directed bench for fib_seq_checker with hand-computed expectations.
module tb_fib_seq_checker;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       restart = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic [3:0] expected;
    logic       err_pulse;
    logic       mismatch_sticky;
    logic [7:0] term_cnt;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    fib_seq_checker #(
        .W(4),
        .CW(8),
        .CHECK_SEED(1'b1),
        .SEED0(1),
        .SEED1(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_data(in_data),
        .restart(restart),
        .clr_err(clr_err),
        .locked(locked),
        .expected(expected),
        .err_pulse(err_pulse),
        .mismatch_sticky(mismatch_sticky),
        .term_cnt(term_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic [3:0] d, input logic rs, input logic ce);
        in_valid = v;
        in_data  = d;
        restart  = rs;
        clr_err  = ce;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        restart  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        total++;
        if ({locked, expected, err_pulse, mismatch_sticky, term_cnt, err_cnt} !== 23'd0) begin
            bad++;
            $display("FAIL reset_vals: got %b required 0",
                     {locked, expected, err_pulse, mismatch_sticky, term_cnt, err_cnt});
        end
        do_reset();
        send(4'd1); send(4'd1); send(4'd2);
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || term_cnt !== 8'd0 || expected !== 4'd0) begin
            bad++;
            $display("FAIL async_reset: locked=%b term=%0d exp=%0d required 0 0 0",
                     locked, term_cnt, expected);
        end
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [3:0] seq [15] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5,
                                 4'd2, 4'd7, 4'd9, 4'd0, 4'd9, 4'd9, 4'd2};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send(seq[i]);
            if (i == 0) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_unlocked_1st: locked=%b required 0", locked);
                end
            end
            if (i == 1) begin
                total++;
                if (locked !== 1'b1 || expected !== 4'd2) begin
                    bad++;
                    $display("FAIL stream_lock_2nd: locked=%b exp=%0d required 1 2", locked, expected);
                end
            end
        end
        total++;
        if (err_cnt !== 8'd0 || term_cnt !== 8'd15 || locked !== 1'b1 || expected !== 4'd11) begin
            bad++;
            $display("FAIL stream_end: err=%0d term=%0d locked=%b exp=%0d required 0 15 1 11",
                     err_cnt, term_cnt, locked, expected);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send(4'd1); send(4'd1); send(4'd2); send(4'd3); send(4'd5); send(4'd8); send(4'd13);
        total++;
        if (expected !== 4'd5) begin
            bad++;
            $display("FAIL wrap_pred21: exp=%0d required 5", expected);
        end
        send(4'd5); send(4'd2);
        total++;
        if (expected !== 4'd7 || err_cnt !== 8'd0 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL wrap_after: exp=%0d err=%0d pulse=%b required 7 0 0",
                     expected, err_cnt, err_pulse);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        send(4'd1); send(4'd1); send(4'd2); send(4'd3);
        send(4'd6);
        total++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || mismatch_sticky !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_flag: pulse=%b err=%0d sticky=%b locked=%b required 1 1 1 0",
                     err_pulse, err_cnt, mismatch_sticky, locked);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        total++;
        if (err_pulse !== 1'b0 || mismatch_sticky !== 1'b1 || term_cnt !== 8'd5) begin
            bad++;
            $display("FAIL mismatch_pulse_once: pulse=%b sticky=%b term=%0d required 0 1 5",
                     err_pulse, mismatch_sticky, term_cnt);
        end
        send(4'd4);
        total++;
        if (locked !== 1'b1 || expected !== 4'd10 || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL mismatch_relock: locked=%b exp=%0d err=%0d required 1 10 1",
                     locked, expected, err_cnt);
        end
    endtask

    task automatic test_seed_check();
        do_reset();
        send(4'd2);
        total++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL seed0_bad: pulse=%b err=%0d locked=%b required 1 1 0",
                     err_pulse, err_cnt, locked);
        end
        send(4'd1);
        total++;
        if (err_pulse !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL seed0_stayed_idle: pulse=%b locked=%b required 0 0", err_pulse, locked);
        end
        send(4'd1); send(4'd2);
        total++;
        if (locked !== 1'b1 || err_cnt !== 8'd1 || term_cnt !== 8'd4 || expected !== 4'd3) begin
            bad++;
            $display("FAIL seed_relock: locked=%b err=%0d term=%0d exp=%0d required 1 1 4 3",
                     locked, err_cnt, term_cnt, expected);
        end
        do_reset();
        send(4'd1); send(4'd3);
        total++;
        if (err_pulse !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1) begin
            bad++;
            $display("FAIL seed1_bad: pulse=%b locked=%b err=%0d required 1 0 1",
                     err_pulse, locked, err_cnt);
        end
    endtask

    task automatic test_restart();
        do_reset();
        send(4'd2);
        send(4'd1); send(4'd1); send(4'd2); send(4'd3);
        drive(1'b1, 4'd5, 1'b1, 1'b0);
        total++;
        if (term_cnt !== 8'd0 || locked !== 1'b0 || err_cnt !== 8'd1 || mismatch_sticky !== 1'b1
            || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL restart_drop: term=%0d locked=%b err=%0d sticky=%b pulse=%b required 0 0 1 1 0",
                     term_cnt, locked, err_cnt, mismatch_sticky, err_pulse);
        end
        send(4'd1); send(4'd1); send(4'd2); send(4'd3);
        total++;
        if (err_cnt !== 8'd1 || term_cnt !== 8'd4 || locked !== 1'b1 || expected !== 4'd5) begin
            bad++;
            $display("FAIL restart_resync: err=%0d term=%0d locked=%b exp=%0d required 1 4 1 5",
                     err_cnt, term_cnt, locked, expected);
        end
    endtask

    task automatic test_clr_and_sat();
        do_reset();
        send(4'd3);
        send(4'd1); send(4'd1); send(4'd2);
        drive(1'b1, 4'd9, 1'b0, 1'b1);
        total++;
        if (err_cnt !== 8'd1 || mismatch_sticky !== 1'b1 || err_pulse !== 1'b1) begin
            bad++;
            $display("FAIL clr_vs_err: err=%0d sticky=%b pulse=%b required 1 1 1",
                     err_cnt, mismatch_sticky, err_pulse);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        total++;
        if (err_cnt !== 8'd0 || mismatch_sticky !== 1'b0) begin
            bad++;
            $display("FAIL clr_only: err=%0d sticky=%b required 0 0", err_cnt, mismatch_sticky);
        end
        send(4'd0);
        drive(1'b1, 4'd1, 1'b1, 1'b1);
        total++;
        if (err_cnt !== 8'd0 || mismatch_sticky !== 1'b0 || term_cnt !== 8'd0 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL restart_and_clr: err=%0d sticky=%b term=%0d pulse=%b required 0 0 0 0",
                     err_cnt, mismatch_sticky, term_cnt, err_pulse);
        end
        for (int i = 0; i < 300; i++) begin
            send(4'd0);
        end
        total++;
        if (term_cnt !== 8'd255 || err_cnt !== 8'd255 || mismatch_sticky !== 1'b1) begin
            bad++;
            $display("FAIL saturate: term=%0d err=%0d sticky=%b required 255 255 1",
                     term_cnt, err_cnt, mismatch_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wrap();
        test_mismatch();
        test_seed_check();
        test_restart();
        test_clr_and_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
